// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter: FSM encoding,
// digit width and the counter sizing helper.
package bin_to_bcd_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int BCD_W = 4;

  // Bits needed to hold the shift count WIDTH down to 0.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle of the converter.
// Handshake: a request is accepted on a rising edge where start=1 and in_ready=1; bin_in
// is captured on that edge. out_valid is a one-cycle pulse marking a new bcd_out/overflow,
// which then hold until the next result.
interface bin_to_bcd_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                start;
  logic [WIDTH-1:0]    bin_in;
  logic                in_ready;
  logic [4*DIGITS-1:0] bcd_out;
  logic                out_valid;
  logic                overflow;

  modport master (
    output start, bin_in,
    input  in_ready, bcd_out, out_valid, overflow
  );

  modport slave (
    input  start, bin_in,
    output in_ready, bcd_out, out_valid, overflow
  );
endinterface

// File: rtl/bin_to_bcd_seq_bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_add3
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [BCD_W-1:0] digit_i,
  output logic [BCD_W-1:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle, result registered and held
// between conversions so downstream display logic never sees intermediate digits.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  bin_to_bcd_seq_if.slave  bus,
  output state_e           dbg_state_o
);

  localparam int BW = BCD_W * DIGITS;
  localparam int SW = BW + WIDTH;
  localparam int CW = cnt_w(WIDTH);

  state_e          state_q, state_d;
  logic [SW-1:0]   scr_q, scr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            ovfo_q, ovfo_d;
  logic            valid_q, valid_d;
  logic [BW-1:0]   adj;
  logic [SW-1:0]   shifted;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit_i (scr_q[WIDTH + g*BCD_W +: BCD_W]),
      .digit_o (adj[g*BCD_W +: BCD_W])
    );
  end

  // The top bit of the corrected top digit falls off here; it is the overflow carry.
  assign shifted = {adj[BW-2:0], scr_q[WIDTH-1:0], 1'b0};

  always_comb begin
    state_d = state_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    bcd_d   = bcd_q;
    ovfo_d  = ovfo_q;
    valid_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          scr_d   = {{BW{1'b0}}, bus.bin_in};
          cnt_d   = CW'(WIDTH);
          ovf_d   = 1'b0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        scr_d = shifted;
        ovf_d = ovf_q | adj[BW-1];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        bcd_d   = scr_q[SW-1:WIDTH];
        ovfo_d  = ovf_q;
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      scr_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      bcd_q   <= '0;
      ovfo_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      bcd_q   <= bcd_d;
      ovfo_q  <= ovfo_d;
      valid_q <= valid_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.bcd_out   = bcd_q;
  assign bus.overflow  = ovfo_q;
  assign bus.out_valid = valid_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: a 3-digit and a 2-digit instance, driven by tasks,
// results checked against expected queues by independent monitors.
module tb_bin_to_bcd_seq;
  import bin_to_bcd_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bin_to_bcd_seq_if #(.WIDTH(8), .DIGITS(3)) bus ();
  bin_to_bcd_seq_if #(.WIDTH(8), .DIGITS(2)) bus2 ();
  state_e dbg3, dbg2;

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .dbg_state_o(dbg3));

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .dbg_state_o(dbg2));

  logic [12:0] exp_q[$];
  logic [8:0]  exp2_q[$];
  logic        chk_period = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [12:0] ref_bcd(input int v);
    return {1'b0, 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // ---------------- monitors ----------------
  logic [11:0] last_bcd = '0;
  int          prev_cyc = 0;
  int          seen5 = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      last_bcd = '0;
    end else if (bus.out_valid) begin
      if (exp_q.size() == 0) check("unexpected_valid", 32'(bus.bcd_out), 32'hdead);
      else check("result3", 32'({bus.overflow, bus.bcd_out}), 32'(exp_q.pop_front()));
      last_bcd = bus.bcd_out;
      if (chk_period) begin
        if (seen5 > 0) check("valid_period", 32'(cyc - prev_cyc), 32'd10);
        seen5++;
      end else seen5 = 0;
      prev_cyc = cyc;
    end else if (bus.bcd_out !== last_bcd) begin
      check("bcd_stable", 32'(bus.bcd_out), 32'(last_bcd));
    end
  end

  logic [7:0] last_bcd2 = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      last_bcd2 = '0;
    end else if (bus2.out_valid) begin
      if (exp2_q.size() == 0) check("unexpected_valid2", 32'(bus2.bcd_out), 32'hdead);
      else check("result2", 32'({bus2.overflow, bus2.bcd_out}), 32'(exp2_q.pop_front()));
      last_bcd2 = bus2.bcd_out;
    end else if (bus2.bcd_out !== last_bcd2) begin
      check("bcd_stable2", 32'(bus2.bcd_out), 32'(last_bcd2));
    end
  end

  // ---------------- drivers ----------------
  task automatic wait_ready();
    int t = 0;
    while (!bus.in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) check("ready_timeout", 32'(bus.in_ready), 32'd1);
  endtask

  // Returns on the negedge right after the accepting edge.
  task automatic issue(input logic [7:0] v, input logic push, input logic [12:0] e);
    wait_ready();
    bus.start  = 1'b1;
    bus.bin_in = v;
    if (push) exp_q.push_back(e);
    @(negedge clk);
    bus.start  = 1'b0;
    bus.bin_in = 8'($urandom_range(0, 255));
  endtask

  task automatic issue2(input logic [7:0] v, input logic [8:0] e);
    int t = 0;
    while (!bus2.in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("ready2", 32'(bus2.in_ready), 32'd1);
    bus2.start  = 1'b1;
    bus2.bin_in = v;
    exp2_q.push_back(e);
    @(negedge clk);
    bus2.start  = 1'b0;
    bus2.bin_in = 8'($urandom_range(0, 255));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;  bus.bin_in = '0;
    bus2.start = 1'b0; bus2.bin_in = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_bcd", 32'(bus.bcd_out), 32'd0);
    check("rst_state", 32'(dbg3), 32'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // Zero, with exact latency: pulse in cycle 9 after the accept edge.
    issue(8'd0, 1'b1, 13'h000);
    repeat (8) @(negedge clk);
    check("latency_low", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("latency_pulse", 32'(bus.out_valid), 32'd1);

    issue(8'd255, 1'b1, 13'h255);
    issue(8'd99,  1'b1, 13'h099);
    issue(8'd100, 1'b1, 13'h100);

    // A start during SHIFT is ignored and bin_in changes do not leak in.
    issue(8'd42, 1'b1, 13'h042);
    for (int i = 0; i < 9; i++) begin
      check("busy_in_ready", 32'(bus.in_ready), 32'd0);
      if (i == 3) begin bus.start = 1'b1; bus.bin_in = 8'd7; end
      if (i == 4) begin bus.start = 1'b0; bus.bin_in = 8'd199; end
      @(negedge clk);
    end
    check("done_in_ready", 32'(bus.in_ready), 32'd1);

    // Abort mid-conversion with reset: no pulse, outputs cleared at once.
    issue(8'd200, 1'b0, 13'h000);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_valid", 32'(bus.out_valid), 32'd0);
    check("abort_bcd", 32'(bus.bcd_out), 32'd0);
    check("abort_state", 32'(dbg3), 32'(ST_IDLE));
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    issue(8'd13, 1'b1, 13'h013);

    // Start held high: back-to-back conversions every 10 cycles.
    wait_ready();
    chk_period = 1'b1;
    bus.start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_ready();
      bus.bin_in = 8'(120 + k);
      exp_q.push_back(ref_bcd(120 + k));
      @(negedge clk);
    end
    bus.start = 1'b0;
    wait_ready();
    @(negedge clk);
    chk_period = 1'b0;

    // Two-digit instance: modulo result with overflow, then a clean one.
    issue2(8'd255, 9'h155);
    issue2(8'd98,  9'h098);
    issue2(8'd0,   9'h000);

    repeat (15) @(negedge clk);
    check("queue3_drained", 32'(exp_q.size()), 32'd0);
    check("queue2_drained", 32'(exp2_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
